// File: rtl/iir_biquad_cascade.sv
// Time-multiplexed cascade of direct-form-I biquad sections sharing one multiplier.
// Each accepted sample runs LOAD, then 5 MACs plus a STORE per section, then OUTPUT.
module iir_biquad_cascade #(
    parameter int P_DATA_MSB     = 15,
    parameter int P_NUM_SECTIONS = 2,
    parameter int P_NUM_CHANNELS = 2,
    parameter int P_COEFF_FRAC   = 14,
    parameter int P_ADDR_MSB     = 5,
    parameter int P_CHAN_MSB     = 0
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_sample_stb,
    input  logic [P_CHAN_MSB:0]   i_sample_chan,
    input  logic [P_DATA_MSB:0]   i_sample_data,
    output logic                  o_sample_ack,
    output logic                  o_result_stb,
    output logic [P_CHAN_MSB:0]   o_result_chan,
    output logic [P_DATA_MSB:0]   o_result_data,
    input  logic                  i_coeff_write_stb,
    input  logic [P_ADDR_MSB:0]   i_coeff_write_addr,
    input  logic [P_DATA_MSB:0]   i_coeff_write_data,
    output logic                  o_coeff_write_ack,
    input  logic                  i_clear_stb,
    output logic                  o_busy
);

    localparam int unsigned DW     = P_DATA_MSB + 1;
    localparam int unsigned CHAN_W = P_CHAN_MSB + 1;
    localparam int unsigned PROD_W = 2 * DW;
    localparam int unsigned ACC_W  = 2 * DW + 4;
    localparam int unsigned NCOEF  = 5 * P_NUM_SECTIONS;
    localparam int unsigned CIDX_W = $clog2(NCOEF);
    localparam int unsigned SEC_W  = (P_NUM_SECTIONS > 1) ? $clog2(P_NUM_SECTIONS) : 1;

    localparam logic signed [ACC_W-1:0] L_SAT_MAX = ACC_W'((2 ** (DW - 1)) - 1);
    localparam logic signed [ACC_W-1:0] L_SAT_MIN = ACC_W'(-(2 ** (DW - 1)));

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_STORE,
        S_OUTPUT
    } state_t;

    state_t                    r_state;
    logic                      r_ready;
    logic [SEC_W-1:0]          r_sec;
    logic [2:0]                r_k;
    logic [CHAN_W-1:0]         r_chan;
    logic signed [DW-1:0]      r_x;
    logic signed [ACC_W-1:0]   r_acc;

    logic signed [DW-1:0]      r_coef [NCOEF];
    logic signed [DW-1:0]      r_x1   [P_NUM_CHANNELS][P_NUM_SECTIONS];
    logic signed [DW-1:0]      r_x2   [P_NUM_CHANNELS][P_NUM_SECTIONS];
    logic signed [DW-1:0]      r_y1   [P_NUM_CHANNELS][P_NUM_SECTIONS];
    logic signed [DW-1:0]      r_y2   [P_NUM_CHANNELS][P_NUM_SECTIONS];

    logic [CIDX_W-1:0]         w_cidx;
    logic signed [DW-1:0]      w_opnd;
    logic signed [PROD_W-1:0]  w_prod;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic signed [ACC_W-1:0]   w_acc_shr;
    logic signed [DW-1:0]      w_sat;
    logic                      w_chan_ok;
    logic                      w_addr_ok;

    assign w_cidx     = CIDX_W'(5 * r_sec + r_k);
    assign w_prod     = r_coef[w_cidx] * w_opnd;
    assign w_prod_ext = ACC_W'(w_prod);
    assign w_acc_shr  = r_acc >>> P_COEFF_FRAC;
    assign w_chan_ok  = 32'(i_sample_chan) < 32'(P_NUM_CHANNELS);
    assign w_addr_ok  = 32'(i_coeff_write_addr) < 32'(NCOEF);

    // Tap order matches coefficient order b0, b1, b2, a1, a2.
    always_comb begin
        w_opnd = r_x;
        case (r_k)
            3'd0:    w_opnd = r_x;
            3'd1:    w_opnd = r_x1[r_chan][r_sec];
            3'd2:    w_opnd = r_x2[r_chan][r_sec];
            3'd3:    w_opnd = r_y1[r_chan][r_sec];
            default: w_opnd = r_y2[r_chan][r_sec];
        endcase
    end

    always_comb begin
        w_sat = w_acc_shr[DW-1:0];
        if (w_acc_shr > L_SAT_MAX) begin
            w_sat = {1'b0, {(DW - 1){1'b1}}};
        end else if (w_acc_shr < L_SAT_MIN) begin
            w_sat = {1'b1, {(DW - 1){1'b0}}};
        end
    end

    // r_ready holds off requests until the first edge after reset release has passed.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state           <= S_IDLE;
            r_ready           <= 1'b0;
            r_sec             <= '0;
            r_k               <= '0;
            r_chan            <= '0;
            r_x               <= '0;
            r_acc             <= '0;
            o_sample_ack      <= 1'b0;
            o_result_stb      <= 1'b0;
            o_result_chan     <= '0;
            o_result_data     <= '0;
            o_coeff_write_ack <= 1'b0;
            o_busy            <= 1'b0;
            for (int i = 0; i < int'(NCOEF); i++) begin
                r_coef[i] <= '0;
            end
            for (int c = 0; c < P_NUM_CHANNELS; c++) begin
                for (int s = 0; s < P_NUM_SECTIONS; s++) begin
                    r_x1[c][s] <= '0;
                    r_x2[c][s] <= '0;
                    r_y1[c][s] <= '0;
                    r_y2[c][s] <= '0;
                end
            end
        end else begin
            r_ready           <= 1'b1;
            o_sample_ack      <= 1'b0;
            o_result_stb      <= 1'b0;
            o_coeff_write_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_ready) begin
                        if (i_coeff_write_stb) begin
                            o_coeff_write_ack <= 1'b1;
                            if (w_addr_ok) begin
                                r_coef[CIDX_W'(i_coeff_write_addr)] <= i_coeff_write_data;
                            end
                        end else if (i_clear_stb) begin
                            for (int c = 0; c < P_NUM_CHANNELS; c++) begin
                                for (int s = 0; s < P_NUM_SECTIONS; s++) begin
                                    r_x1[c][s] <= '0;
                                    r_x2[c][s] <= '0;
                                    r_y1[c][s] <= '0;
                                    r_y2[c][s] <= '0;
                                end
                            end
                        end else if (i_sample_stb) begin
                            o_sample_ack <= 1'b1;
                            if (w_chan_ok) begin
                                r_chan  <= i_sample_chan;
                                r_x     <= i_sample_data;
                                r_state <= S_LOAD;
                                o_busy  <= 1'b1;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    r_acc   <= '0;
                    r_sec   <= '0;
                    r_k     <= '0;
                    r_state <= S_MAC;
                end
                S_MAC: begin
                    if (r_k >= 3'd3) begin
                        r_acc <= r_acc - w_prod_ext;
                    end else begin
                        r_acc <= r_acc + w_prod_ext;
                    end
                    if (r_k == 3'd4) begin
                        r_k     <= '0;
                        r_state <= S_STORE;
                    end else begin
                        r_k <= r_k + 3'd1;
                    end
                end
                S_STORE: begin
                    r_x2[r_chan][r_sec] <= r_x1[r_chan][r_sec];
                    r_x1[r_chan][r_sec] <= r_x;
                    r_y2[r_chan][r_sec] <= r_y1[r_chan][r_sec];
                    r_y1[r_chan][r_sec] <= w_sat;
                    r_x                 <= w_sat;
                    r_acc               <= '0;
                    if (r_sec == SEC_W'(P_NUM_SECTIONS - 1)) begin
                        r_state <= S_OUTPUT;
                    end else begin
                        r_sec   <= r_sec + SEC_W'(1);
                        r_state <= S_MAC;
                    end
                end
                S_OUTPUT: begin
                    o_result_stb  <= 1'b1;
                    o_result_data <= r_x;
                    o_result_chan <= r_chan;
                    o_busy        <= 1'b0;
                    r_state       <= S_IDLE;
                end
                default: begin
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iir_biquad_cascade.sv
// Directed bench for iir_biquad_cascade: vector table plus hand-written timing sequences.
module tb_iir_biquad_cascade;

    logic        clk;
    logic        rst_n;
    logic        sample_stb;
    logic [0:0]  sample_chan;
    logic [15:0] sample_data;
    logic        sample_ack;
    logic        result_stb;
    logic [0:0]  result_chan;
    logic [15:0] result_data;
    logic        cw_stb;
    logic [5:0]  cw_addr;
    logic [15:0] cw_data;
    logic        cw_ack;
    logic        clear_stb;
    logic        busy;

    int n_total = 0;
    int n_pass  = 0;

    iir_biquad_cascade dut (
        .i_clk              (clk),
        .i_reset_n          (rst_n),
        .i_sample_stb       (sample_stb),
        .i_sample_chan      (sample_chan),
        .i_sample_data      (sample_data),
        .o_sample_ack       (sample_ack),
        .o_result_stb       (result_stb),
        .o_result_chan      (result_chan),
        .o_result_data      (result_data),
        .i_coeff_write_stb  (cw_stb),
        .i_coeff_write_addr (cw_addr),
        .i_coeff_write_data (cw_data),
        .o_coeff_write_ack  (cw_ack),
        .i_clear_stb        (clear_stb),
        .o_busy             (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          grp;
        logic [0:0]  chan;
        logic [15:0] din;
        logic [15:0] dout;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_sample_ack(output bit got);
        got = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (sample_ack) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    // Called at the negedge right after the capturing edge; counts edges to the result.
    task automatic wait_result(input logic [0:0] ch, input logic [15:0] exp, input string nm);
        int          n_res;
        logic [15:0] held;
        n_res = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 5) check({nm, " busy"}, 32'(busy), 32'(1));
            if (result_stb) begin
                n_res = n;
                break;
            end
        end
        check({nm, " latency"}, 32'(n_res), 32'(14));
        check({nm, " data"}, 32'(result_data), 32'(exp));
        check({nm, " chan"}, 32'(result_chan), 32'(ch));
        held = result_data;
        @(negedge clk);
        check({nm, " stb pulse"}, 32'(result_stb), 32'(0));
        check({nm, " hold"}, 32'(result_data), 32'(held));
    endtask

    task automatic run_sample(input logic [0:0] ch, input logic [15:0] din, input logic [15:0] dout,
                              input string nm);
        bit got;
        sample_stb  = 1'b1;
        sample_chan = ch;
        sample_data = din;
        wait_sample_ack(got);
        sample_stb = 1'b0;
        check({nm, " ack"}, 32'(got), 32'(1));
        if (got) wait_result(ch, dout, nm);
    endtask

    task automatic wr_coef(input logic [5:0] addr, input logic [15:0] data);
        bit got;
        got     = 1'b0;
        cw_stb  = 1'b1;
        cw_addr = addr;
        cw_data = data;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (cw_ack) begin
                got = 1'b1;
                break;
            end
        end
        cw_stb = 1'b0;
        check($sformatf("wr ack addr %0d", addr), 32'(got), 32'(1));
    endtask

    task automatic do_clear();
        clear_stb = 1'b1;
        @(negedge clk);
        clear_stb = 1'b0;
    endtask

    task automatic setup_group(input int g);
        case (g)
            1: begin
                wr_coef(6'd0, 16'h4000);
                wr_coef(6'd5, 16'h4000);
            end
            2: begin
                wr_coef(6'd3, 16'hE000);
                do_clear();
            end
            3: begin
                wr_coef(6'd0, 16'h7FFF);
                wr_coef(6'd5, 16'h7FFF);
                wr_coef(6'd3, 16'h0000);
            end
            default: ;
        endcase
    endtask

    initial begin
        bit          got;
        int          cur_grp;
        int          n_res;
        int          n_ack;
        bit          seen;
        logic [15:0] res;

        vecs[0]  = '{1, 1'b0, 16'h1234, 16'h1234};
        vecs[1]  = '{1, 1'b1, 16'h8000, 16'h8000};
        vecs[2]  = '{1, 1'b0, 16'h7FFF, 16'h7FFF};
        vecs[3]  = '{1, 1'b1, 16'hFFFF, 16'hFFFF};
        vecs[4]  = '{2, 1'b1, 16'h4000, 16'h4000};
        vecs[5]  = '{2, 1'b0, 16'h0000, 16'h0000};
        vecs[6]  = '{2, 1'b1, 16'h0000, 16'h2000};
        vecs[7]  = '{2, 1'b0, 16'h0000, 16'h0000};
        vecs[8]  = '{2, 1'b1, 16'h0000, 16'h1000};
        vecs[9]  = '{2, 1'b0, 16'h0000, 16'h0000};
        vecs[10] = '{2, 1'b1, 16'h0000, 16'h0800};
        vecs[11] = '{3, 1'b0, 16'h7000, 16'h7FFF};
        vecs[12] = '{3, 1'b0, 16'h9000, 16'h8000};
        vecs[13] = '{3, 1'b1, 16'h0100, 16'h03FD};
        vecs[14] = '{3, 1'b1, 16'hFF00, 16'hFC00};

        // Requests held during reset must be ignored.
        rst_n       = 1'b0;
        sample_stb  = 1'b1;
        sample_chan = 1'b0;
        sample_data = 16'h1000;
        cw_stb      = 1'b1;
        cw_addr     = 6'd0;
        cw_data     = 16'h4000;
        clear_stb   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'(0));
        check("reset sample ack", 32'(sample_ack), 32'(0));
        check("reset wr ack", 32'(cw_ack), 32'(0));
        check("reset result stb", 32'(result_stb), 32'(0));
        check("reset result data", 32'(result_data), 32'(0));
        cw_stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("first edge after release no ack", 32'(sample_ack), 32'(0));
        @(negedge clk);
        check("second edge after release ack", 32'(sample_ack), 32'(1));
        sample_stb = 1'b0;
        wait_result(1'b0, 16'h0000, "zero coeffs");

        cur_grp = 0;
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].grp != cur_grp) begin
                cur_grp = vecs[i].grp;
                setup_group(cur_grp);
            end
            run_sample(vecs[i].chan, vecs[i].din, vecs[i].dout, $sformatf("vec%0d", i));
        end

        // Coefficient write while busy waits for IDLE.
        sample_stb  = 1'b1;
        sample_chan = 1'b0;
        sample_data = 16'h0100;
        wait_sample_ack(got);
        sample_stb = 1'b0;
        check("busy wr: sample ack", 32'(got), 32'(1));
        cw_stb  = 1'b1;
        cw_addr = 6'd0;
        cw_data = 16'h4000;
        n_res   = 0;
        n_ack   = 0;
        res     = 16'h0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (result_stb && n_res == 0) begin
                n_res = n;
                res   = result_data;
            end
            if (cw_ack) begin
                n_ack = n;
                break;
            end
        end
        cw_stb = 1'b0;
        check("busy wr: result latency", 32'(n_res), 32'(14));
        check("busy wr: result data", 32'(res), 32'(16'h03FD));
        check("busy wr: ack edge", 32'(n_ack), 32'(15));
        run_sample(1'b0, 16'h0100, 16'h01FF, "after busy wr");

        // Write and sample together: write first, sample one cycle later.
        cw_stb      = 1'b1;
        cw_addr     = 6'd5;
        cw_data     = 16'h4000;
        sample_stb  = 1'b1;
        sample_chan = 1'b1;
        sample_data = 16'h0100;
        @(negedge clk);
        check("simul: wr ack first", 32'(cw_ack), 32'(1));
        check("simul: sample waits", 32'(sample_ack), 32'(0));
        cw_stb = 1'b0;
        @(negedge clk);
        check("simul: sample ack next", 32'(sample_ack), 32'(1));
        sample_stb = 1'b0;
        wait_result(1'b1, 16'h0100, "simul");

        // Out-of-range address must not alias onto a real coefficient.
        wr_coef(6'd16, 16'h1234);
        run_sample(1'b0, 16'h2345, 16'h2345, "bad addr");

        // Clear returns the recursive filter to its post-reset response.
        wr_coef(6'd3, 16'hE000);
        do_clear();
        run_sample(1'b0, 16'h4000, 16'h4000, "impulse a");
        do_clear();
        run_sample(1'b0, 16'h4000, 16'h4000, "impulse after clear");
        run_sample(1'b0, 16'h0000, 16'h2000, "tail after clear");
        wr_coef(6'd3, 16'h0000);

        // Back-to-back: held request is taken the cycle after OUTPUT.
        sample_stb  = 1'b1;
        sample_chan = 1'b0;
        sample_data = 16'h1111;
        wait_sample_ack(got);
        check("b2b: first ack", 32'(got), 32'(1));
        sample_chan = 1'b1;
        sample_data = 16'h2222;
        n_res = 0;
        n_ack = 0;
        res   = 16'h0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (result_stb && n_res == 0) begin
                n_res = n;
                res   = result_data;
            end
            if (sample_ack) begin
                n_ack = n;
                break;
            end
        end
        sample_stb = 1'b0;
        check("b2b: first latency", 32'(n_res), 32'(14));
        check("b2b: first data", 32'(res), 32'(16'h1111));
        check("b2b: second ack edge", 32'(n_ack), 32'(15));
        wait_result(1'b1, 16'h2222, "b2b second");

        // Reset in the middle of the MAC phase aborts the sample.
        sample_stb  = 1'b1;
        sample_chan = 1'b0;
        sample_data = 16'h1234;
        wait_sample_ack(got);
        sample_stb = 1'b0;
        check("abort: ack", 32'(got), 32'(1));
        repeat (3) @(negedge clk);
        check("abort: busy before reset", 32'(busy), 32'(1));
        rst_n = 1'b0;
        #1;
        check("abort: busy async", 32'(busy), 32'(0));
        check("abort: result data async", 32'(result_data), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (result_stb) seen = 1'b1;
        end
        check("abort: no result", 32'(seen), 32'(0));
        run_sample(1'b0, 16'h1234, 16'h0000, "coeffs cleared by reset");
        wr_coef(6'd0, 16'h4000);
        wr_coef(6'd5, 16'h4000);
        run_sample(1'b0, 16'h1234, 16'h1234, "passthrough after abort");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
